// File: rtl/usc_rv_int_wb_arb.sv
// Integer writeback arbiter: merges ALU, LSU and MDU results onto the single
// registered register-file write port. It also keeps a per-register pending
// scoreboard for RAW stalls and a saturating count of arbitration-loss cycles.
//
// Handshake (LSU and MDU): a transfer completes on a rising edge where
// vld & rdy = 1. rdy is combinational and may depend on vld. Once a source
// raises vld, it holds vld, atag and data stable until it sees rdy = 1.
// The ALU has no ready and is always accepted.
module usc_rv_int_wb_arb #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alu_vld,
   input  logic [$clog2(NREG)-1:0]  alu_atag,
   input  logic [XLEN-1:0]          alu_data,
   input  logic                     lsu_vld,
   output logic                     lsu_rdy,
   input  logic [$clog2(NREG)-1:0]  lsu_atag,
   input  logic [XLEN-1:0]          lsu_data,
   input  logic                     mdu_vld,
   output logic                     mdu_rdy,
   input  logic [$clog2(NREG)-1:0]  mdu_atag,
   input  logic [XLEN-1:0]          mdu_data,
   input  logic                     iss_vld,
   input  logic [$clog2(NREG)-1:0]  iss_atag,
   output logic                     wr_vld,
   output logic [$clog2(NREG)-1:0]  wr_atag,
   output logic [XLEN-1:0]          wr_data,
   output logic [NREG-1:0]          busy,
   output logic [CNT_W-1:0]         conflict_cnt
);

   localparam int TW = $clog2(NREG);

   // Round-robin pointer between LSU and MDU: 0 prefers LSU, 1 prefers MDU.
   logic             rr_q, rr_d;
   logic             wr_vld_q, wr_vld_d;
   logic [TW-1:0]    wr_atag_q, wr_atag_d;
   logic [XLEN-1:0]  wr_data_q, wr_data_d;
   logic [NREG-1:0]  busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             gnt_alu, gnt_lsu, gnt_mdu, gnt_any, conflict;
   logic [TW-1:0]    sel_atag;
   logic [XLEN-1:0]  sel_data;

   // Grant: ALU has absolute priority, and the pointer breaks LSU/MDU ties.
   always_comb begin
      gnt_alu = alu_vld;
      gnt_lsu = !alu_vld && lsu_vld && (!mdu_vld || !rr_q);
      gnt_mdu = !alu_vld && mdu_vld && (!lsu_vld || rr_q);
      gnt_any = gnt_alu || gnt_lsu || gnt_mdu;
      // A valid LSU/MDU result left waiting this cycle is an arbitration loss.
      conflict = (lsu_vld && !gnt_lsu) || (mdu_vld && !gnt_mdu);
   end

   // Mux the winning source onto the write-port inputs.
   always_comb begin
      sel_atag = alu_atag;
      sel_data = alu_data;
      if (gnt_lsu) begin
         sel_atag = lsu_atag;
         sel_data = lsu_data;
      end else if (gnt_mdu) begin
         sel_atag = mdu_atag;
         sel_data = mdu_data;
      end
   end

   // Next-state: write port, pointer, scoreboard and conflict counter.
   always_comb begin
      // Writes to x0 complete the handshake but never reach the RF.
      wr_vld_d  = gnt_any && (sel_atag != '0);
      wr_atag_d = wr_vld_d ? sel_atag : wr_atag_q;
      wr_data_d = wr_vld_d ? sel_data : wr_data_q;

      rr_d = rr_q;
      if (gnt_lsu) begin
         rr_d = 1'b1;
      end else if (gnt_mdu) begin
         rr_d = 1'b0;
      end

      // Clear first, then set, so a same-register race leaves the bit pending.
      busy_d = busy_q;
      if (wr_vld_q) begin
         busy_d[wr_atag_q] = 1'b0;
      end
      if (iss_vld && (iss_atag != '0)) begin
         busy_d[iss_atag] = 1'b1;
      end
      busy_d[0] = 1'b0;

      cnt_d = cnt_q;
      if (conflict && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers with synchronous reset; reset drops any in-flight result.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_q      <= 1'b0;
         wr_vld_q  <= 1'b0;
         wr_atag_q <= '0;
         wr_data_q <= '0;
         busy_q    <= '0;
         cnt_q     <= '0;
      end else begin
         rr_q      <= rr_d;
         wr_vld_q  <= wr_vld_d;
         wr_atag_q <= wr_atag_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
      end
   end

   assign lsu_rdy      = gnt_lsu;
   assign mdu_rdy      = gnt_mdu;
   assign wr_vld       = wr_vld_q;
   assign wr_atag      = wr_atag_q;
   assign wr_data      = wr_data_q;
   assign busy         = busy_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_usc_rv_int_wb_arb.sv
// Bench for usc_rv_int_wb_arb: directed vectors, a spec-level reference model
// checked every cycle, and literal expectations for the test-plan scenarios.
module tb_usc_rv_int_wb_arb;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        alu_vld = 1'b0, lsu_vld = 1'b0, mdu_vld = 1'b0, iss_vld = 1'b0;
   logic [4:0]  alu_atag = '0, lsu_atag = '0, mdu_atag = '0, iss_atag = '0;
   logic [31:0] alu_data = '0, lsu_data = '0, mdu_data = '0;
   logic        lsu_rdy, mdu_rdy, wr_vld;
   logic [4:0]  wr_atag;
   logic [31:0] wr_data;
   logic [31:0] busy;
   logic [15:0] conflict_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   usc_rv_int_wb_arb #(.XLEN(32), .NREG(32), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .alu_vld(alu_vld), .alu_atag(alu_atag), .alu_data(alu_data),
      .lsu_vld(lsu_vld), .lsu_rdy(lsu_rdy), .lsu_atag(lsu_atag), .lsu_data(lsu_data),
      .mdu_vld(mdu_vld), .mdu_rdy(mdu_rdy), .mdu_atag(mdu_atag), .mdu_data(mdu_data),
      .iss_vld(iss_vld), .iss_atag(iss_atag),
      .wr_vld(wr_vld), .wr_atag(wr_atag), .wr_data(wr_data),
      .busy(busy), .conflict_cnt(conflict_cnt)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Who wins this cycle: 0 nobody, 1 ALU, 2 LSU, 3 MDU.
   bit          m_prefer_mdu = 1'b0;
   bit          m_wr_vld = 1'b0;
   logic [4:0]  m_wr_atag = '0;
   logic [31:0] m_wr_data = '0;
   logic [31:0] m_busy = '0;
   int          m_cnt = 0;

   function automatic int winner();
      if (alu_vld) return 1;
      if (lsu_vld && mdu_vld) return m_prefer_mdu ? 3 : 2;
      if (lsu_vld) return 2;
      if (mdu_vld) return 3;
      return 0;
   endfunction

   always @(posedge clk) begin
      int w;
      logic [4:0]  t;
      logic [31:0] d;
      if (reset) begin
         m_prefer_mdu = 1'b0;
         m_wr_vld = 1'b0;
         m_wr_atag = '0;
         m_wr_data = '0;
         m_busy = '0;
         m_cnt = 0;
      end else begin
         w = winner();
         if ((lsu_vld && w != 2) || (mdu_vld && w != 3)) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
         if (m_wr_vld) m_busy[m_wr_atag] = 1'b0;
         if (iss_vld && iss_atag != 0) m_busy[iss_atag] = 1'b1;
         t = (w == 1) ? alu_atag : (w == 2) ? lsu_atag : mdu_atag;
         d = (w == 1) ? alu_data : (w == 2) ? lsu_data : mdu_data;
         m_wr_vld = (w != 0) && (t != 0);
         if (m_wr_vld) begin
            m_wr_atag = t;
            m_wr_data = d;
         end
         if (w == 2) m_prefer_mdu = 1'b1;
         if (w == 3) m_prefer_mdu = 1'b0;
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      int w;
      if (chk_en) begin
         w = winner();
         chk("lsu_rdy", {63'd0, lsu_rdy}, {63'd0, (w == 2)});
         chk("mdu_rdy", {63'd0, mdu_rdy}, {63'd0, (w == 3)});
         chk("wr_vld", {63'd0, wr_vld}, {63'd0, m_wr_vld});
         chk("wr_atag", {59'd0, wr_atag}, {59'd0, m_wr_atag});
         chk("wr_data", {32'd0, wr_data}, {32'd0, m_wr_data});
         chk("busy", {32'd0, busy}, {32'd0, m_busy});
         chk("conflict_cnt", {48'd0, conflict_cnt}, 64'(m_cnt));
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic idle();
      alu_vld = 1'b0; lsu_vld = 1'b0; mdu_vld = 1'b0; iss_vld = 1'b0;
   endtask

   logic [4:0] lq[$];
   logic [4:0] mq[$];
   int got[$];
   int exp_rr[8];

   initial begin
      bit lf, mf;
      int first_c, last_c;

      tick();
      chk_en = 1'b1;
      tick();
      reset = 1'b0;

      // Reset state
      at_neg();
      chk("rst_wr_vld", {63'd0, wr_vld}, 64'd0);
      chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
      chk("rst_busy", {32'd0, busy}, 64'd0);
      chk("rst_cnt", {48'd0, conflict_cnt}, 64'd0);

      // ALU only
      tick();
      alu_vld = 1'b1; alu_atag = 5'd5; alu_data = 32'h1234;
      tick();
      alu_vld = 1'b0;
      at_neg();
      chk("alu_wr_vld", {63'd0, wr_vld}, 64'd1);
      chk("alu_wr_atag", {59'd0, wr_atag}, 64'd5);
      chk("alu_wr_data", {32'd0, wr_data}, 64'h1234);
      tick();
      at_neg();
      chk("alu_wr_vld_drop", {63'd0, wr_vld}, 64'd0);
      chk("alu_wr_data_hold", {32'd0, wr_data}, 64'h1234);

      // ALU vs load
      tick();
      alu_vld = 1'b1; alu_atag = 5'd1; alu_data = 32'h11;
      lsu_vld = 1'b1; lsu_atag = 5'd7; lsu_data = 32'h77;
      at_neg();
      chk("alu_vs_lsu_rdy0", {63'd0, lsu_rdy}, 64'd0);
      tick();
      alu_atag = 5'd2; alu_data = 32'h22;
      at_neg();
      chk("alu_vs_lsu_rdy1", {63'd0, lsu_rdy}, 64'd0);
      tick();
      alu_vld = 1'b0;
      at_neg();
      chk("alu_vs_lsu_rdy2", {63'd0, lsu_rdy}, 64'd1);
      chk("alu_vs_lsu_cnt", {48'd0, conflict_cnt}, 64'd2);
      tick();
      lsu_vld = 1'b0;
      at_neg();
      chk("load_wr_atag", {59'd0, wr_atag}, 64'd7);
      chk("load_wr_data", {32'd0, wr_data}, 64'h77);

      // Round robin after a fresh reset
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      lq = '{5'd10, 5'd11, 5'd12, 5'd13};
      mq = '{5'd20, 5'd21, 5'd22, 5'd23};
      exp_rr = '{10, 20, 11, 21, 12, 22, 13, 23};
      first_c = -1; last_c = -1;
      for (int c = 0; c < 40 && got.size() < 8; c++) begin
         lsu_vld = (lq.size() > 0);
         if (lq.size() > 0) begin lsu_atag = lq[0]; lsu_data = 32'hA000 + 32'(lq[0]); end
         mdu_vld = (mq.size() > 0);
         if (mq.size() > 0) begin mdu_atag = mq[0]; mdu_data = 32'hB000 + 32'(mq[0]); end
         at_neg();
         lf = lsu_vld && lsu_rdy;
         mf = mdu_vld && mdu_rdy;
         if (wr_vld) begin
            got.push_back(int'(wr_atag));
            if (first_c < 0) first_c = c;
            last_c = c;
         end
         tick();
         if (lf) void'(lq.pop_front());
         if (mf) void'(mq.pop_front());
      end
      idle();
      chk("rr_write_count", 64'(got.size()), 64'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < got.size()) chk("rr_order", 64'(got[i]), 64'(exp_rr[i]));
      end
      chk("rr_back_to_back", 64'(last_c - first_c), 64'd7);
      at_neg();
      chk("rr_cnt", {48'd0, conflict_cnt}, 64'd7);

      // x0 discard
      tick();
      lsu_vld = 1'b1; lsu_atag = 5'd0; lsu_data = 32'h5;
      iss_vld = 1'b1; iss_atag = 5'd0;
      at_neg();
      chk("x0_lsu_rdy", {63'd0, lsu_rdy}, 64'd1);
      tick();
      idle();
      at_neg();
      chk("x0_wr_vld", {63'd0, wr_vld}, 64'd0);
      chk("x0_busy", {32'd0, busy}, 64'd0);
      tick();
      lsu_vld = 1'b1; lsu_atag = 5'd4; lsu_data = 32'h44;
      mdu_vld = 1'b1; mdu_atag = 5'd6; mdu_data = 32'h66;
      at_neg();
      chk("x0_rr_mdu_wins", {63'd0, mdu_rdy}, 64'd1);
      tick();
      mdu_vld = 1'b0;
      at_neg();
      chk("x0_then_lsu", {63'd0, lsu_rdy}, 64'd1);
      chk("x0_mdu_written", {59'd0, wr_atag}, 64'd6);
      tick();
      idle();

      // Scoreboard race
      iss_vld = 1'b1; iss_atag = 5'd9;
      tick();
      iss_vld = 1'b0;
      at_neg();
      chk("sb_set9", {63'd0, busy[9]}, 64'd1);
      tick();
      alu_vld = 1'b1; alu_atag = 5'd9; alu_data = 32'h99;
      tick();
      alu_vld = 1'b0;
      iss_vld = 1'b1; iss_atag = 5'd9;
      tick();
      iss_vld = 1'b0;
      at_neg();
      chk("sb_set_wins", {63'd0, busy[9]}, 64'd1);
      alu_vld = 1'b1; alu_atag = 5'd9; alu_data = 32'h999;
      tick();
      alu_vld = 1'b0;
      tick();
      at_neg();
      chk("sb_clear9", {63'd0, busy[9]}, 64'd0);
      iss_vld = 1'b1; iss_atag = 5'd9;
      tick();
      iss_vld = 1'b0;
      alu_vld = 1'b1; alu_atag = 5'd9; alu_data = 32'h9999;
      tick();
      alu_vld = 1'b0;
      iss_vld = 1'b1; iss_atag = 5'd3;
      tick();
      iss_vld = 1'b0;
      at_neg();
      chk("sb_set3", {63'd0, busy[3]}, 64'd1);
      chk("sb_clr9_diff", {63'd0, busy[9]}, 64'd0);

      // Saturation, then a one-cycle reset mid-stream
      tick();
      alu_vld = 1'b1; alu_atag = 5'd1; alu_data = 32'h1;
      lsu_vld = 1'b1; lsu_atag = 5'd8; lsu_data = 32'h88;
      repeat (70000) tick();
      at_neg();
      chk("sat_cnt", {48'd0, conflict_cnt}, 64'hFFFF);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      at_neg();
      chk("mid_rst_wr_vld", {63'd0, wr_vld}, 64'd0);
      chk("mid_rst_wr_atag", {59'd0, wr_atag}, 64'd0);
      chk("mid_rst_wr_data", {32'd0, wr_data}, 64'd0);
      chk("mid_rst_busy", {32'd0, busy}, 64'd0);
      chk("mid_rst_cnt", {48'd0, conflict_cnt}, 64'd0);
      tick();
      alu_vld = 1'b0;
      mdu_vld = 1'b1; mdu_atag = 5'd12; mdu_data = 32'hC;
      at_neg();
      chk("mid_rst_rr_lsu", {63'd0, lsu_rdy}, 64'd1);
      chk("mid_rst_rr_mdu", {63'd0, mdu_rdy}, 64'd0);
      tick();
      idle();
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/usc_rv_int_wb_arb.md
Name: usc_rv_int_wb_arb

Overview:
- Integer writeback stage directly upstream of the integer register file.
- Collects results from the ALU, the LSU (load return) and the MDU (mul/div), and arbitrates them onto the single registered RF write port.
- Keeps a per-register pending scoreboard so issue logic can stall on RAW hazards.
- Counts arbitration-loss cycles for performance analysis.

Parameters:
- XLEN, 32, data width of results and of the RF write port.
- NREG, 32, number of architectural integer registers; tag width is log2(NREG) = 5.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- alu_vld  in  1  ALU result valid; cannot be back-pressured
- alu_atag  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- lsu_vld  in  1  load result valid
- lsu_rdy  out  1  load result accepted this cycle
- lsu_atag  in  5  load destination register
- lsu_data  in  XLEN  load result
- mdu_vld  in  1  MDU result valid
- mdu_rdy  out  1  MDU result accepted this cycle
- mdu_atag  in  5  MDU destination register
- mdu_data  in  XLEN  MDU result
- iss_vld  in  1  issue stage allocates a destination this cycle
- iss_atag  in  5  allocated destination register
- wr_vld  out  1  RF write enable (registered)
- wr_atag  out  5  RF write address (registered)
- wr_data  out  XLEN  RF write data (registered)
- busy  out  NREG  per-register pending-write bits; bit 0 always 0
- conflict_cnt  out  CNT_W  saturating count of cycles in which a valid LSU/MDU result was not accepted

Behaviour:
- One clock, synchronous active-high reset.
  - In the reset cycle: wr_vld=0, wr_atag=0, wr_data=0, busy=0, conflict_cnt=0, rr pointer=0 (LSU preferred).
  - Reset asserted mid-operation discards any in-flight result. The RF sees no write in the cycle after reset.
- Arbitration (combinational grant each cycle):
  - alu_vld=1: the ALU always wins; lsu_rdy=0, mdu_rdy=0.
  - Else, only one of lsu_vld/mdu_vld set: that source is granted (its rdy=1).
  - Else, both set: grant follows rr (0 = LSU, 1 = MDU).
  - rr updates only on a granted LSU/MDU transfer: LSU grant sets rr=1, MDU grant sets rr=0. An ALU grant leaves rr unchanged.
  - rdy may depend on vld. A source must hold vld, atag and data stable until it sees rdy=1. A transfer completes on a clock edge with vld&rdy=1.
- Output register, latency 1:
  - The granted result appears on wr_* in the cycle after the grant.
  - wr_vld=0 when nothing was granted. wr_atag/wr_data hold their previous value when wr_vld=0.
  - A result with atag=0 is accepted (handshake completes, rr updates) but produces wr_vld=0.
- Scoreboard:
  - On an edge with iss_vld=1 and iss_atag!=0: busy[iss_atag] <= 1.
  - On an edge with wr_vld=1: busy[wr_atag] <= 0. busy therefore drops in the same cycle the RF holds the new data.
  - Set and clear of the same register on the same edge: set wins, so busy stays 1.
  - Set and clear of different registers on the same edge: both take effect.
  - busy[0] is hardwired 0.
  - Writeback to a register whose busy bit is 0 is legal; that bit stays 0.
- Conflict counter:
  - Increments by 1 on each edge where (lsu_vld&!lsu_rdy) | (mdu_vld&!mdu_rdy).
  - A cycle with both sources blocked still counts +1.
  - Saturates at 2^CNT_W-1; no wrap.

Test Plan:
- Reset then ALU only: alu_vld=1, alu_atag=5, alu_data=0x1234 at cycle N -> wr_vld=1, wr_atag=5, wr_data=0x1234 at N+1; wr_vld=0 at N+2.
- ALU vs load: alu_vld=1 and lsu_vld=1 (atag=7) held for 3 cycles, ALU dropping after cycle 2 -> lsu_rdy=0 for 2 cycles, then 1; conflict_cnt=2; load written on the cycle after its grant.
- Round robin: lsu_vld and mdu_vld both held with 4 queued results each, no ALU -> grants alternate LSU, MDU, LSU, MDU… starting with LSU after reset; 8 writes in 8 consecutive cycles.
- x0 discard: lsu_vld=1, lsu_atag=0 -> lsu_rdy=1, wr_vld stays 0, rr toggles to 1; busy[0] stays 0 even with iss_vld=1, iss_atag=0.
- Scoreboard race: iss x9 -> busy[9]=1; issue a new x9 on the same edge as its writeback (wr_vld=1, wr_atag=9) -> busy[9] stays 1. The next write to x9 clears it. A simultaneous issue of x3 and writeback of x9 sets bit 3 and clears bit 9.
- Saturation and reset: LSU valid held with ALU hogging for 70000 cycles -> conflict_cnt=0xFFFF. Then assert reset for 1 cycle mid-stream -> all outputs 0 next cycle, rr=0.
